// File: rtl/mem_lsu.sv
// mem_lsu: single-entry memory stage. Holds one op from EX, issues an aligned
// data-memory access when needed, and forwards the RF write to the next stage.
module mem_lsu #(
    parameter int DW = 32,
    parameter int BW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic          in_rf_we,
    input  logic [4:0]    in_rf_waddr,
    input  logic [DW-1:0] in_ex_result,
    input  logic          in_ld,
    input  logic          in_st,
    input  logic [1:0]    in_size,
    input  logic          in_sign,
    input  logic [DW-1:0] in_st_data,
    output logic          dmem_req,
    input  logic          dmem_gnt,
    output logic [BW-1:0] dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_rvalid,
    input  logic [DW-1:0] dmem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic          out_rf_we,
    output logic [4:0]    out_rf_waddr,
    output logic [DW-1:0] out_rf_wdata,
    output logic          out_misalign,
    output logic          fwd_we,
    output logic [4:0]    fwd_waddr,
    output logic [DW-1:0] fwd_wdata,
    output logic          fwd_pending
);
    localparam int OW = $clog2(BW);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [DW-1:0] res_q, res_d;      // address/ALU result, replaced by load data
    logic          ld_q, ld_d, st_q, st_d, sign_q, sign_d, mis_q, mis_d;
    logic [1:0]    size_q, size_d;
    logic [DW-1:0] sdata_q, sdata_d;

    logic          accept, mem_in, mis_in;
    logic [OW-1:0] off;
    int            nbytes;
    logic [BW-1:0] be;
    logic [DW-1:0] rep, sh, mask, ld_val;

    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign mem_in   = in_ld || in_st;

    // Flag incoming memory ops whose address is not naturally aligned
    always_comb begin
        mis_in = 1'b0;
        if (mem_in) begin
            case (in_size)
                2'd1:    mis_in = in_ex_result[0];
                2'd2:    mis_in = |in_ex_result[1:0];
                2'd3:    mis_in = |in_ex_result[2:0];
                default: mis_in = 1'b0;
            endcase
        end
    end

    // Lane enables, store replication and load extraction for the held op
    always_comb begin
        off    = res_q[OW-1:0];
        nbytes = 1 << size_q;
        be     = '1;
        if (nbytes < BW) be = ~({BW{1'b1}} << nbytes);
        be  = be << off;
        rep = '0;
        for (int i = 0; i < BW; i++) rep[i*8 +: 8] = sdata_q[8*(i % nbytes) +: 8];
        sh   = dmem_rdata >> {off, 3'b000};
        mask = '1;
        if (8 * nbytes < DW) mask = ~({DW{1'b1}} << (8 * nbytes));
        // mask & ~(mask >> 1) isolates the sign bit of the selected lane
        ld_val = sh & mask;
        if (sign_q && |(sh & mask & ~(mask >> 1))) ld_val = sh | ~mask;
    end

    // Next state and stage-register contents
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rf_we_d = rf_we_q;
        waddr_d = waddr_q;
        res_d   = res_q;
        ld_d    = ld_q;
        st_d    = st_q;
        sign_d  = sign_q;
        mis_d   = mis_q;
        size_d  = size_q;
        sdata_d = sdata_q;
        case (state_q)
            REQ:  if (dmem_gnt) state_d = ld_q ? WAIT : DONE;
            WAIT: if (dmem_rvalid) begin
                res_d   = ld_val;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: ;
        endcase
        if (accept) begin
            pc_d    = in_pc;
            rf_we_d = in_rf_we && !in_st && !mis_in;
            waddr_d = in_rf_waddr;
            res_d   = in_ex_result;
            ld_d    = in_ld;
            st_d    = in_st;
            sign_d  = in_sign;
            mis_d   = mis_in;
            size_d  = in_size;
            sdata_d = in_st_data;
            state_d = (mem_in && !mis_in) ? REQ : DONE;
        end
    end

    // State and stage register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            rf_we_q <= 1'b0;
            waddr_q <= '0;
            res_q   <= '0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            sign_q  <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rf_we_q <= rf_we_d;
            waddr_q <= waddr_d;
            res_q   <= res_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            sign_q  <= sign_d;
            mis_q   <= mis_d;
            size_q  <= size_d;
            sdata_q <= sdata_d;
        end
    end

    // Memory request is presented only in REQ, held until granted
    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = (dmem_req && st_q) ? be : '0;
    assign dmem_addr  = dmem_req ? {res_q[DW-1:OW], {OW{1'b0}}} : '0;
    assign dmem_wdata = (dmem_req && st_q) ? rep : '0;

    assign out_valid    = (state_q == DONE);
    assign out_pc       = out_valid ? pc_q : '0;
    assign out_rf_we    = out_valid && rf_we_q;
    assign out_rf_waddr = out_valid ? waddr_q : '0;
    assign out_rf_wdata = out_valid ? res_q : '0;
    assign out_misalign = out_valid && mis_q;

    // Forwarding view of the held op; data is not yet valid while a load is in flight
    assign fwd_we      = (state_q != IDLE) && rf_we_q;
    assign fwd_waddr   = (state_q != IDLE) ? waddr_q : '0;
    assign fwd_wdata   = (state_q != IDLE) ? res_q : '0;
    assign fwd_pending = (state_q == REQ || state_q == WAIT) && ld_q;
endmodule
